// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and line levels
package uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

   localparam logic UART_IDLE_LEVEL  = 1'b1;
   localparam logic UART_START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// rtl/uart_tx_serializer_if.sv - byte valid/ready handshake into the UART transmitter
interface uart_tx_serializer_if #(
   parameter int DATA_BITS = 8
);

   logic                 tx_valid;
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_ready;

   modport master (output tx_valid, output tx_data, input tx_ready);
   modport slave  (input tx_valid, input tx_data, output tx_ready);

endinterface

// File: rtl/uart_baud_counter.sv
// rtl/uart_baud_counter.sv - bit-period counter, tick on terminal count
module uart_baud_counter #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick = (cnt_q == CW'(CLKS_PER_BIT - 1));

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clear || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART transmitter: start bit, LSB-first data, stop bits
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   uart_tx_serializer_if.slave        tx_if,
   output logic                       tx_serial,
   output logic                       tx_busy,
   output logic                       tx_done
);

   localparam int BW = $clog2(DATA_BITS);

   uart_tx_state_t       state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic                 serial_q, serial_d;
   logic                 ready_q, ready_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 handshake;
   logic                 tick;

   assign handshake = tx_if.tx_valid && ready_q;

   uart_baud_counter #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk   (clk),
      .rst   (rst),
      .clear (handshake),
      .tick  (tick)
   );

   // bit_q counts data bits in DATA and is reused to count stop bits in STOP
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      bit_d    = bit_q;
      serial_d = serial_q;
      ready_d  = ready_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (handshake) begin
               state_d  = START;
               shift_d  = tx_if.tx_data;
               bit_d    = '0;
               serial_d = UART_START_LEVEL;
               ready_d  = 1'b0;
               busy_d   = 1'b1;
            end
         end
         START: begin
            if (tick) begin
               state_d  = DATA;
               serial_d = shift_q[0];
            end
         end
         DATA: begin
            if (tick) begin
               if (bit_q == BW'(DATA_BITS - 1)) begin
                  state_d  = STOP;
                  bit_d    = '0;
                  serial_d = UART_IDLE_LEVEL;
               end else begin
                  shift_d  = shift_q >> 1;
                  bit_d    = bit_q + 1'b1;
                  serial_d = shift_q[1];
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (bit_q == BW'(STOP_BITS - 1)) begin
                  state_d = IDLE;
                  bit_d   = '0;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  ready_d = 1'b1;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         bit_q    <= '0;
         serial_q <= UART_IDLE_LEVEL;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         bit_q    <= bit_d;
         serial_q <= serial_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign tx_if.tx_ready = ready_q;
   assign tx_serial      = serial_q;
   assign tx_busy        = busy_q;
   assign tx_done        = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - self-checking bench for uart_tx_serializer
module tb_uart_tx_serializer;

   localparam int C = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       sel;
   logic       valid;
   logic [7:0] data;

   always #5 clk = ~clk;

   uart_tx_serializer_if #(.DATA_BITS(8)) ifa ();
   uart_tx_serializer_if #(.DATA_BITS(8)) ifb ();

   assign ifa.tx_valid = valid & ~sel;
   assign ifa.tx_data  = data;
   assign ifb.tx_valid = valid & sel;
   assign ifb.tx_data  = data;

   logic sa, ba, da, sb, bb, db;

   uart_tx_serializer #(.DATA_BITS(8), .CLKS_PER_BIT(C), .STOP_BITS(1)) dut_a (
      .clk(clk), .rst(rst), .tx_if(ifa), .tx_serial(sa), .tx_busy(ba), .tx_done(da)
   );
   uart_tx_serializer #(.DATA_BITS(8), .CLKS_PER_BIT(C), .STOP_BITS(2)) dut_b (
      .clk(clk), .rst(rst), .tx_if(ifb), .tx_serial(sb), .tx_busy(bb), .tx_done(db)
   );

   logic ser, rdy, bsy, dne;
   assign ser = sel ? sb : sa;
   assign rdy = sel ? ifb.tx_ready : ifa.tx_ready;
   assign bsy = sel ? bb : ba;
   assign dne = sel ? db : da;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      logic [7:0]  data;
      logic [10:0] frame;
      int          glitch;
   } vec_t;

   vec_t       tbl[$];
   logic       line_q[$];
   logic [7:0] rx_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // line levels of one frame, one entry per bit, bit 0 is the start bit
   function automatic logic [10:0] frame_bits(input logic [7:0] b, input int nstop);
      logic [10:0] f;
      f = '1;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[1+i] = b[i];
      for (int i = 9 + nstop; i < 11; i++) f[i] = 1'b1;
      return f;
   endfunction

   task automatic wait_ready();
      int n = 0;
      while (!rdy && n < 100) begin
         step();
         n++;
      end
      check("ready_wait", rdy, 1);
   endtask

   task automatic send_check(input logic [7:0] b, input int nstop, input logic [10:0] fr, input int glitch);
      int len;
      len = (1 + 8 + nstop) * C;
      valid = 1'b1;
      data  = b;
      wait_ready();
      step();
      valid = 1'b0;
      data  = 8'($urandom);
      for (int k = 0; k < len; k++) begin
         if (k == glitch) begin
            valid = 1'b1;
            data  = 8'h00;
         end else begin
            valid = 1'b0;
         end
         check($sformatf("serial[%0h] k=%0d", b, k), ser, fr[k / C]);
         check($sformatf("rdy_bsy_dne[%0h] k=%0d", b, k), {rdy, bsy, dne}, 3'b010);
         step();
      end
      valid = 1'b0;
      check($sformatf("end_rdy_bsy_dne[%0h]", b), {rdy, bsy, dne}, 3'b101);
      check($sformatf("end_serial[%0h]", b), ser, 1);
      step();
      check($sformatf("done_once[%0h]", b), {ser, rdy, bsy, dne}, 4'b1100);
   endtask

   task automatic decode_line();
      int i = 0;
      logic [7:0] b;
      rx_q.delete();
      while (i + 9 * C + C / 2 < line_q.size()) begin
         if (line_q[i] == 1'b0) begin
            for (int j = 0; j < 8; j++) b[j] = line_q[i + C / 2 + C * (j + 1)];
            rx_q.push_back(b);
            i = i + 9 * C + C / 2 + 1;
         end else begin
            i++;
         end
      end
   endtask

   initial begin
      int n;
      int nd;
      rst   = 1'b1;
      sel   = 1'b0;
      valid = 1'b0;
      data  = 8'h00;
      step();
      step();
      rst = 1'b0;

      for (int k = 0; k < 20; k++) begin
         check($sformatf("idle k=%0d", k), {ser, rdy, bsy, dne}, 4'b1100);
         step();
      end

      tbl.push_back('{8'hA5, 11'b11101001010, -1});
      tbl.push_back('{8'h00, 11'b11000000000, -1});
      tbl.push_back('{8'hFF, 11'b11111111110, -1});
      tbl.push_back('{8'h81, 11'b11100000010, 12});
      for (int r = 0; r < 6; r++) begin
         logic [7:0] rb;
         rb = 8'($urandom);
         tbl.push_back('{rb, frame_bits(rb, 1), -1});
      end
      foreach (tbl[i]) send_check(tbl[i].data, 1, tbl[i].frame, tbl[i].glitch);

      // back-to-back: valid held across the frame, next byte offered in the done cycle
      line_q.delete();
      valid = 1'b1;
      data  = 8'h3C;
      wait_ready();
      step();
      n = 0;
      while (!dne && n < 100) begin
         line_q.push_back(ser);
         step();
         n++;
      end
      check("b2b_done_seen", dne, 1);
      check("b2b_done_at", n, 40);
      line_q.push_back(ser);
      data = 8'hFF;
      step();
      valid = 1'b0;
      check("b2b_second_start", {ser, bsy}, 2'b01);
      for (int k = 0; k < 60; k++) begin
         line_q.push_back(ser);
         step();
      end
      decode_line();
      check("b2b_rx_count", rx_q.size(), 2);
      if (rx_q.size() > 0) check("b2b_rx0", rx_q[0], 8'h3C);
      if (rx_q.size() > 1) check("b2b_rx1", rx_q[1], 8'hFF);

      // reset in the middle of data bit 3
      valid = 1'b1;
      data  = 8'h55;
      wait_ready();
      step();
      valid = 1'b0;
      for (int k = 1; k < 18; k++) step();
      rst = 1'b1;
      step();
      check("rst_serial", ser, 1);
      check("rst_rdy_bsy_dne", {rdy, bsy, dne}, 3'b100);
      rst = 1'b0;
      nd = 0;
      for (int k = 0; k < 60; k++) begin
         if (dne) nd++;
         step();
      end
      check("rst_no_done", nd, 0);
      send_check(8'h12, 1, frame_bits(8'h12, 1), -1);

      // two stop bits
      sel = 1'b1;
      step();
      send_check(8'hC3, 2, 11'b11110000110, -1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
